// File: rtl/red_pitaya_pwm_bank.sv
// Multi-channel PWM DAC bank: base PWM period plus bit-reversed sub-LSB dither
// over a frame, codes from the system bus or live DSP samples, latched at frame end.
module red_pitaya_pwm_bank #(
   parameter int CHN       = 4,
   parameter int PWM_BITS  = 8,
   parameter int DITH_BITS = 4,
   parameter int IN_W      = 14
)(
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic [CHN*IN_W-1:0]   dsp_i,
   output logic [CHN-1:0]        pwm_o,
   output logic                  frame_o,
   input  logic [31:0]           sys_addr,
   input  logic [31:0]           sys_wdata,
   input  logic [3:0]            sys_sel,
   input  logic                  sys_wen,
   input  logic                  sys_ren,
   output logic [31:0]           sys_rdata,
   output logic                  sys_err,
   output logic                  sys_ack
);

   localparam int CODE_W = PWM_BITS + DITH_BITS;

   logic [PWM_BITS-1:0]               r_cnt;
   logic [DITH_BITS-1:0]              r_fcnt;
   logic                              r_frame;
   logic                              r_ack;
   logic [31:0]                       r_rdata;
   logic [CHN-1:0]                    r_src;
   logic [CHN-1:0]                    r_pwm;
   logic [CHN-1:0][CODE_W-1:0]        r_val;
   logic [CHN-1:0][CODE_W-1:0]        r_act;
   logic [CHN-1:0][PWM_BITS:0]        r_thr;

   logic                              w_cnt_max;
   logic                              w_fb;
   logic [DITH_BITS-1:0]              w_fcnt_inc;
   logic [DITH_BITS-1:0]              w_fcnt_rev;
   logic [19:0]                       w_addr;
   logic                              w_val_sel;
   logic                              w_act_sel;
   logic                              w_src_sel;
   logic                              w_info_sel;
   logic [CHN-1:0]                    w_idx_hit;
   logic [CHN-1:0][CODE_W-1:0]        w_dsp_code;
   logic [CHN-1:0][CODE_W-1:0]        w_act_next;
   logic [CHN-1:0][PWM_BITS:0]        w_thr_next;
   logic [31:0]                       w_rdata;
   logic                              w_unused;

   assign w_cnt_max  = &r_cnt;
   assign w_fb       = w_cnt_max & (&r_fcnt);
   assign w_fcnt_inc = r_fcnt + DITH_BITS'(1);

   // Bit-reversed frame index spreads the extra high clocks evenly over the frame.
   genvar gi;
   generate
      for (gi = 0; gi < DITH_BITS; gi++) begin : g_rev
         assign w_fcnt_rev[gi] = w_fcnt_inc[DITH_BITS-1-gi];
      end
   endgenerate

   assign w_addr     = sys_addr[19:0];
   assign w_val_sel  = (w_addr[19:6] == 14'h0) && (w_addr[1:0] == 2'b00);
   assign w_act_sel  = (w_addr[19:6] == 14'h2) && (w_addr[1:0] == 2'b00);
   assign w_src_sel  = (w_addr == 20'h00040);
   assign w_info_sel = (w_addr == 20'h00044);

   generate
      for (gi = 0; gi < CHN; gi++) begin : g_ch
         logic [IN_W-1:0]     w_off;
         logic [PWM_BITS-1:0] w_d;
         logic                w_ext;

         assign w_idx_hit[gi]  = (w_addr[5:2] == 4'(gi));
         // Signed sample to offset binary, then keep the top CODE_W bits.
         assign w_off          = {~dsp_i[gi*IN_W+IN_W-1], dsp_i[gi*IN_W +: IN_W-1]};
         assign w_dsp_code[gi] = w_off[IN_W-1 -: CODE_W];
         assign w_act_next[gi] = w_fb ? (r_src[gi] ? w_dsp_code[gi] : r_val[gi]) : r_act[gi];
         assign w_d            = w_act_next[gi][CODE_W-1:DITH_BITS];
         assign w_ext          = (w_fcnt_rev < w_act_next[gi][DITH_BITS-1:0]);
         assign w_thr_next[gi] = {1'b0, w_d} + {{PWM_BITS{1'b0}}, w_ext};
      end
   endgenerate

   always_comb begin
      w_rdata = 32'h0;
      for (int i = 0; i < CHN; i++) begin
         if (w_val_sel && w_idx_hit[i]) w_rdata = 32'(r_val[i]);
         if (w_act_sel && w_idx_hit[i]) w_rdata = 32'(r_act[i]);
      end
      if (w_src_sel)  w_rdata = 32'(r_src);
      if (w_info_sel) w_rdata = {8'h0, 8'(CHN), 8'(DITH_BITS), 8'(PWM_BITS)};
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_cnt   <= '0;
         r_fcnt  <= '0;
         r_frame <= 1'b0;
         r_ack   <= 1'b0;
         r_rdata <= 32'h0;
         r_src   <= '0;
         r_pwm   <= '0;
         r_val   <= '0;
         r_act   <= '0;
         r_thr   <= '0;
      end else begin
         r_cnt   <= r_cnt + PWM_BITS'(1);
         if (w_cnt_max) r_fcnt <= w_fcnt_inc;
         r_frame <= (r_cnt == '0) && (r_fcnt == '0);
         r_ack   <= sys_wen | sys_ren;
         if (sys_ren) r_rdata <= w_rdata;
         if (sys_wen && w_src_sel) r_src <= sys_wdata[CHN-1:0];
         for (int i = 0; i < CHN; i++) begin
            if (sys_wen && w_val_sel && w_idx_hit[i]) r_val[i] <= sys_wdata[CODE_W-1:0];
            r_act[i] <= w_act_next[i];
            // Threshold for the coming period is fixed in the last cycle of the current one.
            if (w_cnt_max) r_thr[i] <= w_thr_next[i];
            r_pwm[i] <= ({1'b0, r_cnt} < r_thr[i]);
         end
      end
   end

   assign w_unused  = ^{sys_sel, sys_addr[31:20], sys_wdata, dsp_i};
   assign pwm_o     = r_pwm;
   assign frame_o   = r_frame;
   assign sys_rdata = r_rdata;
   assign sys_ack   = r_ack;
   assign sys_err   = 1'b0;

endmodule

// File: doc/red_pitaya_pwm_bank.md
# red_pitaya_pwm_bank

Parametrised multi-channel PWM DAC engine for the slow analog outputs. Each channel takes either a software-written code from the system bus or a live signed sample from the DSP. It drives its PWM pin directly, producing a base PWM period plus a sub-LSB dither pattern spread over a frame of periods. Codes update only on frame boundaries, so outputs are glitch-free. The block sits beside the XADC/housekeeping logic on the same system-bus window style and replaces the fixed two-channel config-word generation.

## Interface
- CHN, 4, number of channels (1..16)
- PWM_BITS, 8, base period = 2^PWM_BITS clocks
- DITH_BITS, 4, frame = 2^DITH_BITS periods; CODE_W = PWM_BITS+DITH_BITS
- IN_W, 14, DSP sample width; IN_W >= CODE_W required

- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- dsp_i  in  CHN*IN_W  signed two's-complement samples, channel n at [n*IN_W +: IN_W]
- pwm_o  out  CHN  registered PWM outputs
- frame_o  out  1  one-cycle pulse aligned with the first pwm_o cycle of each frame
- sys_addr  in  32  bus address, decoded on [19:0]
- sys_wdata  in  32  write data
- sys_sel  in  4  byte select; ignored, all writes are full-word
- sys_wen  in  1  write enable
- sys_ren  in  1  read enable
- sys_rdata  out  32  read data
- sys_err  out  1  always 0
- sys_ack  out  1  acknowledge

## Operation
- Registers:
  - 0x00+4n: VAL[n], R/W, CODE_W bits, zero-extended on read.
  - 0x40: SRC, R/W, CHN bits; bit n=1 selects DSP for channel n.
  - 0x44: INFO, RO, {8'h0, CHN[7:0], DITH_BITS[7:0], PWM_BITS[7:0]}.
  - 0x80+4n: ACT[n], RO, active code.
  - Any other address reads 0. Writes to RO or unmapped addresses are ignored.
- DSP conversion: invert the sample MSB (offset binary), then keep the top CODE_W bits, truncating the LSBs.
- Counters: cnt is PWM_BITS wide and free-running. fcnt is DITH_BITS wide and increments when cnt wraps.
- Frame boundary cycle (FB): cnt=all-ones and fcnt=all-ones. In FB, ACT[n] <= SRC[n] ? converted dsp_i : VAL[n]. The sampled values are the pre-edge values.
- Per period: d = ACT[PWM_BITS+DITH_BITS-1:DITH_BITS] and f = ACT[DITH_BITS-1:0].
  - ext = (bitrev(fcnt_next) < f).
  - thr = d + ext, PWM_BITS+1 bits wide, computed in the cycle where cnt=all-ones for the coming period. In FB it uses the newly loaded ACT.
- pwm_o[n](t+1) = (cnt(t) < thr[n](t)).
- High clocks per frame = d*2^DITH_BITS + f, so mean duty = ACT/2^CODE_W.
- Code 0 gives pwm_o constantly low. Code all-ones gives 2^CODE_W-1 high clocks per frame.
- Bus:
  - sys_ack(t+1) = sys_wen|sys_ren.
  - sys_rdata is registered, valid with ack.
  - Writes land at the edge after the wen cycle.

## Timing
- Reset values: pwm_o=0, frame_o=0, sys_ack=0, sys_err=0, sys_rdata=0, VAL=0, SRC=0, ACT=0, cnt=0, fcnt=0, thr=0.
- Reset is asynchronous. Asserting rstn_i mid-period forces pwm_o low with no clock edge. The first frame after release starts at cnt=0, fcnt=0.
- Latency: pwm_o lags cnt by 1 cycle. frame_o(t+1) = (cnt(t)=0 and fcnt(t)=0).
- A code takes effect from the first frame after the next FB.
- A bus write issued in the FB cycle misses that load and applies one frame later. The same holds for SRC changes.
- DSP samples are sampled only in FB; changes between boundaries are ignored.
- Frame length at defaults is 4096 clocks; period is 256 clocks.
- A bus read and a write to the same register in one cycle returns the old value.

## Test plan
- Reset: hold rstn_i low, then release → pwm_o=0, frame_o=0. Read 0x44 → 0x00040408. Read any VAL/ACT → 0.
- SW dither: write VAL[0]=0x805 and wait one frame past FB → frame high count = 2053. Periods with fcnt ∈ {0,8,4,12,2} are high 129 clocks; all others 128. ACT[0] reads 0x805.
- Extremes: VAL[2]=0xFFF → 15 periods high 256 clocks, fcnt=15 period high 255, total 4095. VAL[2]=0 → pwm_o[2] never high.
- DSP source: SRC=0x2 (channel 1), then drive dsp ch1:
  - 14'h2000 → ACT[1]=0x000, output low.
  - 14'h1FFF → ACT[1]=0xFFF.
  - 14'h0000 → ACT[1]=0x800, exactly 128 high per period.
- Boundary collision: write VAL[3]=0x400 in the FB cycle → ACT[3] keeps its old value for that frame and becomes 0x400 at the next FB. frame_o pulses once per 4096 clocks.
- Mid-frame reset: pull rstn_i low while pwm_o[0]=1 → pwm_o[0]=0 before the next edge. After release, the registers read their reset values and frame_o first pulses 1 cycle after cnt=0, fcnt=0.
